lane_deserializer: RTL
======================

Name: lane_deserializer

Overview:
- Per-lane receive stage directly upstream of the two-lane unstriping mux; one instance per lane.
- Converts the serial bitstream (MSB first) into 32-bit words, aligns to the idle word 32'hBCBCBCBC, and presents data_out/valid_out.
- Idle words are stripped, so the unstriping mux sees valid_out=0 during idle.

Parameters:
- WIDTH, 32: word width in bits.
- IDLE_WORD, 32'hBCBCBCBC: comma/idle pattern sent by the transmitter when it has no valid data.
- ALIGN_COUNT, 4: consecutive boundary-spaced IDLE_WORD matches needed to declare lock.
- LOSS_COUNT, 3: consecutive non-idle, non-data errors tolerated before returning to search; see Behaviour for the error definition.

Ports:
- clk_32f  input  1  bit-rate clock; all state updates on its rising edge.
- reset_L  input  1  asynchronous active-low reset.
- data_in  input  1  serial bit, MSB of each word first.
- data_out  output  WIDTH  last received data word, held between updates.
- valid_out  output  1  high while data_out holds a non-idle word.
- active  output  1  high while the lane is locked (LOCKED state).
- err_out  output  1  one-cycle pulse on each framing error while locked.

Behaviour:
- Reset (reset_L=0, asynchronous): shift_reg=0, bit_cnt=0, match_cnt=0, err_cnt=0, state=SEARCH, data_out=0, valid_out=0, active=0, err_out=0. Asserting reset mid-word discards the partial word immediately.
- Every clock: shift_reg <= {shift_reg[WIDTH-2:0], data_in}. Comparisons use the value after the shift, i.e. {shift_reg[WIDTH-2:0], data_in}, called "next_sr".
- SEARCH:
  - Bit-by-bit sliding compare of next_sr against IDLE_WORD.
  - On match: bit_cnt<=0, match_cnt<=1, go to ALIGN. The word boundary is fixed at this edge.
  - bit_cnt is unused in SEARCH.
- ALIGN:
  - bit_cnt counts 0..WIDTH-1 and wraps. A boundary edge is any edge where bit_cnt==WIDTH-1.
  - At a boundary edge: if next_sr==IDLE_WORD, match_cnt++; otherwise match_cnt<=0 and go to SEARCH.
  - When the incremented match_cnt reaches ALIGN_COUNT: go to LOCKED, active<=1 on that same edge.
  - Total from the first SEARCH match is ALIGN_COUNT matches, ALIGN_COUNT-1 of them at boundaries.
- LOCKED:
  - bit_cnt keeps wrapping, with no re-synchronisation.
  - At a boundary edge, next_sr==IDLE_WORD: valid_out<=0; data_out keeps its previous value; err_cnt<=0.
  - At a boundary edge, other value: data_out<=next_sr, valid_out<=1.
  - Framing error, defined as a K-byte (8'hBC) in byte lanes [15:0] of a non-idle word, i.e. a partial comma:
    - err_out pulses for 1 cycle and err_cnt++.
    - The word is still forwarded.
    - If err_cnt reaches LOSS_COUNT: go to SEARCH; active<=0, valid_out<=0, match_cnt<=0, err_cnt<=0.
  - A clean data word resets err_cnt to 0.
- Latency: the last bit of a word sampled at edge N appears on data_out/valid_out at edge N, registered. Outputs are held stable for WIDTH cycles, the next boundary.
- valid_out and data_out update only in LOCKED. Outside LOCKED: valid_out=0 and data_out holds its last value (0 after reset).
- Simultaneous events: a boundary edge that triggers loss of lock takes priority. valid_out=0 and data_out is unchanged on that edge.
- ALIGN_COUNT=1 is legal: SEARCH goes directly to LOCKED on the first match.

Decomposition:
- Shared package holds:
  - state encoding (SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2)
  - IDLE_WORD and K_BYTE (8'hBC) constants
  - default WIDTH
- The transmit-side serializer uses the same constants.
- One sub-module is natural: lane_align_fsm (state, bit_cnt, match_cnt, err_cnt, active, boundary strobe).
- The shift register and output registers stay in the top.

Test Plan:
- Reset behaviour: reset_L=0 for 5 cycles with random data_in, then released -> all outputs 0 and state SEARCH. A second reset asserted mid-word, asynchronously between edges -> outputs clear immediately, without waiting for a clock edge.
- Align then data: 4 x 32'hBCBCBCBC followed by 32'h12345678, starting at an arbitrary 5-bit offset of junk -> active=1 at the edge of the 4th idle's last bit; data_out=32'h12345678 and valid_out=1 at the next boundary, held 32 cycles.
- Broken alignment: 3 idle words then 32'h00000000, then 4 idle words -> state returns to SEARCH after the zero word; active rises only after the later 4 idles; valid_out stays 0 throughout.
- Idle between data: locked, then send 32'hA5A5A5A5, IDLE, 32'h0F0F0F0F -> valid_out sequence 1,0,1 per boundary; data_out holds A5A5A5A5 during the idle slot.
- Loss of lock: locked, then 3 consecutive words 32'h0000BC00 -> err_out pulses three times; active falls on the 3rd boundary with valid_out=0. Variant with a clean word between errors -> err_cnt resets and no loss of lock.
- Back-to-back data: 100 random non-idle words with no K-bytes -> each appears exactly once on data_out 32 cycles apart; valid_out stays continuously 1.

Source files
------------

// File: rtl/lane_deserializer_pkg.sv
// Shared constants for the lane serializer/deserializer pair: framing words,
// state encoding and the partial-comma test used for framing errors.
package lane_deserializer_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam logic [31:0] IdleWord     = 32'hBCBCBCBC;
    localparam logic [7:0]  KByte        = 8'hBC;

    localparam logic [1:0] StSearch = 2'd0;
    localparam logic [1:0] StAlign  = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    // A K-byte in either low byte lane of a non-idle word is a partial comma.
    function automatic logic has_partial_comma(input logic [15:0] low_bytes);
        return (low_bytes[15:8] == KByte) || (low_bytes[7:0] == KByte);
    endfunction

endpackage

// File: rtl/lane_align_fsm.sv
// Word-alignment state machine: finds the idle comma, confirms it on word
// boundaries, and drops lock after repeated framing errors.
module lane_align_fsm
    import lane_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned ALIGN_COUNT = 4,
    parameter int unsigned LOSS_COUNT  = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic idle_match_i,
    input  logic frame_err_i,
    output logic boundary_o,
    output logic locked_o,
    output logic loss_o
);

    localparam int unsigned CntW   = $clog2(WIDTH);
    localparam int unsigned MatchW = $clog2(ALIGN_COUNT + 1);
    localparam int unsigned ErrW   = $clog2(LOSS_COUNT + 1);

    localparam logic [CntW-1:0]   LastBit  = CntW'(WIDTH - 1);
    localparam logic [MatchW-1:0] MatchTgt = MatchW'(ALIGN_COUNT);
    localparam logic [MatchW-1:0] MatchOne = MatchW'(1);
    localparam logic [ErrW-1:0]   ErrTgt   = ErrW'(LOSS_COUNT);

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [MatchW-1:0] match_cnt_q, match_cnt_d, match_inc;
    logic [ErrW-1:0]   err_cnt_q, err_cnt_d, err_inc;
    logic              boundary;

    assign boundary   = (bit_cnt_q == LastBit);
    assign match_inc  = match_cnt_q + 1'b1;
    assign err_inc    = err_cnt_q + 1'b1;
    assign boundary_o = boundary;
    assign locked_o   = (state_q == StLocked);
    assign loss_o     = locked_o && boundary && !idle_match_i && frame_err_i &&
                        (err_inc == ErrTgt);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (state_q != StSearch) begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        end

        case (state_q)
            StSearch: begin
                // Any match fixes the word boundary at this edge.
                if (idle_match_i) begin
                    bit_cnt_d   = '0;
                    match_cnt_d = MatchOne;
                    state_d     = (MatchTgt == MatchOne) ? StLocked : StAlign;
                end
            end
            StAlign: begin
                if (boundary) begin
                    if (idle_match_i) begin
                        match_cnt_d = match_inc;
                        if (match_inc == MatchTgt) begin
                            state_d = StLocked;
                        end
                    end else begin
                        match_cnt_d = '0;
                        state_d     = StSearch;
                    end
                end
            end
            StLocked: begin
                if (boundary) begin
                    if (idle_match_i || !frame_err_i) begin
                        err_cnt_d = '0;
                    end else if (loss_o) begin
                        err_cnt_d   = '0;
                        match_cnt_d = '0;
                        state_d     = StSearch;
                    end else begin
                        err_cnt_d = err_inc;
                    end
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StSearch;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: rtl/lane_deserializer.sv
// Per-lane receive stage: serial-to-parallel conversion, comma alignment and
// idle stripping ahead of the unstriping mux.
module lane_deserializer
    import lane_deserializer_pkg::*;
#(
    parameter int unsigned       WIDTH       = DefaultWidth,
    parameter logic [WIDTH-1:0]  IDLE_WORD   = WIDTH'(IdleWord),
    parameter int unsigned       ALIGN_COUNT = 4,
    parameter int unsigned       LOSS_COUNT  = 3
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic             err_out
);

    // Only the newest WIDTH-1 bits are kept; the oldest bit is never compared.
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-1:0] next_sr;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             idle_match, frame_err, boundary, locked, loss;

    assign next_sr    = {shift_q, data_in};
    assign idle_match = (next_sr == IDLE_WORD);
    assign frame_err  = has_partial_comma(next_sr[15:0]);

    lane_align_fsm #(
        .WIDTH       (WIDTH),
        .ALIGN_COUNT (ALIGN_COUNT),
        .LOSS_COUNT  (LOSS_COUNT)
    ) u_fsm (
        .clk_i        (clk_32f),
        .rst_ni       (reset_L),
        .idle_match_i (idle_match),
        .frame_err_i  (frame_err),
        .boundary_o   (boundary),
        .locked_o     (locked),
        .loss_o       (loss)
    );

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        if (!locked) begin
            valid_d = 1'b0;
        end else if (boundary) begin
            if (idle_match) begin
                valid_d = 1'b0;
            end else if (loss) begin
                // Losing lock wins: the errored word is not forwarded.
                valid_d = 1'b0;
                err_d   = 1'b1;
            end else begin
                data_d  = next_sr;
                valid_d = 1'b1;
                err_d   = frame_err;
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= next_sr[WIDTH-2:0];
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign err_out   = err_q;
    assign active    = locked;

endmodule
